// File: rtl/ext_fifo_uart_tx.sv
// ext_fifo_uart_tx
//
// Buffers the processor's character-output stream in a small FIFO and
// serialises the low byte of each entry onto a UART TX line (8N1, LSB first).
// Processor writes never stall. When the FIFO is full, a write is dropped and
// the OVERFLOW flag is set.
//
// Optional feature: define EXT_UART_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. This makes each frame 11 bit
// times instead of 10.
//
// Ports:
//   CLK              system clock, rising edge
//   RSTN             asynchronous active-low reset
//   EXT_FIFO_WR_ENB  write strobe, one character per asserted cycle
//   EXT_FIFO_WR_DATA character in bits [7:0], upper bits ignored
//   UART_TX          serial output, idle high, driven from a register
//   FIFO_EMPTY       registered, FIFO holds no entries
//   FIFO_FULL        registered, FIFO holds 2^FIFO_ADDR_WIDTH entries
//   FIFO_COUNT       registered occupancy
//   OVERFLOW         sticky, a write was dropped (cleared only by reset)
//   TX_BUSY          transmitter is not idle
module ext_fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FIFO_ADDR_WIDTH = 5,
    parameter int unsigned CLKS_PER_BIT    = 868
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       EXT_FIFO_WR_ENB,
    input  logic [DATA_WIDTH-1:0]      EXT_FIFO_WR_DATA,
    output logic                       UART_TX,
    output logic                       FIFO_EMPTY,
    output logic                       FIFO_FULL,
    output logic [FIFO_ADDR_WIDTH:0]   FIFO_COUNT,
    output logic                       OVERFLOW,
    output logic                       TX_BUSY
);

    localparam int unsigned DEPTH  = 2 ** FIFO_ADDR_WIDTH;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0]        BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT  = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

`ifdef EXT_UART_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} tx_state_e;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
    logic                       empty_q, full_q, overflow_q;
    logic                       wr_accept, pop;
    logic [7:0]                 head;

    tx_state_e                  state_q;

    // Only the low byte is transmitted.
    logic unused_wr_data;
    assign unused_wr_data = ^EXT_FIFO_WR_DATA[DATA_WIDTH-1:8];

    assign wr_accept = EXT_FIFO_WR_ENB && !full_q;
    // The FSM pops whenever it is idle and the FIFO is non-empty.
    assign pop       = (state_q == StIdle) && !empty_q;
    assign head      = mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];

    // The storage array is not reset. Stale contents are never read, because
    // the read/write pointers and the empty flag are reset.
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= EXT_FIFO_WR_DATA[7:0];
        end
    end

    always_comb begin
        count_d = count_q;
        if (wr_accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == FULL_CNT);
            // Any write seen while full is dropped, even if a pop frees an
            // entry in the same cycle.
            if (EXT_FIFO_WR_ENB && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              busy_q;
`ifdef EXT_UART_PARITY_EN
    logic              parity_q;
`endif

    // tx_q always holds the line level for the coming cycle. It is loaded
    // with the next bit on the same edge that changes state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef EXT_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q  <= head;
`ifdef EXT_UART_PARITY_EN
                        parity_q <= ^head;
`endif
                        bit_q    <= '0;
                        baud_q   <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef EXT_UART_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef EXT_UART_PARITY_EN
                StParity: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign UART_TX    = tx_q;
    assign FIFO_EMPTY = empty_q;
    assign FIFO_FULL  = full_q;
    assign FIFO_COUNT = count_q;
    assign OVERFLOW   = overflow_q;
    assign TX_BUSY    = busy_q;

endmodule
